// File: rtl/nano_dsi_pkg.sv
// Shared state encoding and timer constants for the nano-PMOD DSI link sequencer.
package nano_dsi_pkg;

    localparam int TIMER_W       = 8;
    localparam int TIMER_EXP_BIT = 7;

    typedef logic [TIMER_W-1:0] timer_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLK_START = 3'd1,
        ST_CLK_PRE   = 3'd2,
        ST_BURST     = 3'd3,
        ST_CLK_POST  = 3'd4,
        ST_CLK_STOP  = 3'd5,
        ST_LP_GAP    = 3'd6
    } link_state_e;

    // The down-counter has run out once it wraps below zero.
    function automatic logic timer_expired(input timer_t t);
        return t[TIMER_EXP_BIT];
    endfunction

    // A timed state holds for the load cycle, cfg decrements, and the wrap cycle.
    function automatic int unsigned timed_state_len(input timer_t cfg);
        return 32'(cfg) + 32'd2;
    endfunction

endpackage

// File: rtl/nano_dsi_link_ctrl_if.sv
// Burst request/grant bundle and clock-lane HS handshake for the DSI link sequencer.
interface nano_dsi_link_ctrl_if #(
    parameter int N_REQ = 2
);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] done;
    logic             clk_hs_req;
    logic             clk_hs_rdy;

    // master is the sequencer; slave is the packet sources plus the clock-lane driver.
    modport master (
        input  req,
        input  done,
        input  clk_hs_rdy,
        output grant,
        output clk_hs_req
    );

    modport slave (
        output req,
        output done,
        output clk_hs_rdy,
        input  grant,
        input  clk_hs_req
    );

endinterface

// File: rtl/nano_dsi_rr_arb.sv
// N_REQ round-robin arbiter: the winner and the rotating pointer update only when latch is pulsed.
module nano_dsi_rr_arb #(
    parameter int N_REQ = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             latch,
    output logic             any_req,
    output logic [N_REQ-1:0] winner_oh
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef logic [IDX_W-1:0] idx_t;

    idx_t ptr_q;
    idx_t pick;
    logic hit;

    function automatic idx_t wrap_add(input idx_t base, input int unsigned off);
        int unsigned sum;
        sum = (32'(base) + off) % unsigned'(N_REQ);
        return sum[IDX_W-1:0];
    endfunction

    function automatic logic [N_REQ-1:0] to_onehot(input idx_t idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        hit  = 1'b0;
        pick = ptr_q;
        // Scan from the far end so the candidate nearest the pointer is written last and wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[wrap_add(ptr_q, unsigned'(i))]) begin
                hit  = 1'b1;
                pick = wrap_add(ptr_q, unsigned'(i));
            end
        end
    end

    assign any_req = hit;

    // NOTE: rst_n is synchronous here, so it is tested inside the clocked block like any other input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            winner_oh <= '0;
        end else if (latch && hit) begin
            ptr_q     <= wrap_add(pick, 32'd1);
            winner_oh <= to_onehot(pick);
        end
    end

endmodule

// File: rtl/nano_dsi_link_ctrl.sv
// DSI link sequencer: arbitrates HS bursts and walks the clock lane through pre/post/LP-gap timing.
// Optional: define NANO_DSI_LINK_BTB_EN to chain pending bursts from CLK_POST straight into CLK_PRE.
module nano_dsi_link_ctrl
    import nano_dsi_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nano_dsi_link_ctrl_if.master   bus,
    input  logic [TIMER_W-1:0]     cfg_clk_pre,
    input  logic [TIMER_W-1:0]     cfg_clk_post,
    input  logic [TIMER_W-1:0]     cfg_lp_gap,
    output logic                   busy
);

    link_state_e      state_q;
    link_state_e      state_next;
    timer_t           timer_q;
    timer_t           timer_load;
    logic             timer_done;
    logic             arb_latch;
    logic             arb_any;
    logic             burst_end;
    logic [N_REQ-1:0] winner_oh;
    logic [N_REQ-1:0] grant_q;
    logic             hs_req_q;

    nano_dsi_rr_arb #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.req),
        .latch     (arb_latch),
        .any_req   (arb_any),
        .winner_oh (winner_oh)
    );

    assign timer_done = timer_expired(timer_q);
    // Only the owning source may end the burst; stray done bits are masked off.
    assign burst_end  = |(bus.done & winner_oh);

    always_comb begin
        state_next = state_q;
        arb_latch  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    arb_latch  = 1'b1;
                    state_next = ST_CLK_START;
                end
            end
            ST_CLK_START: begin
                if (bus.clk_hs_rdy) state_next = ST_CLK_PRE;
            end
            ST_CLK_PRE: begin
                if (timer_done) state_next = ST_BURST;
            end
            ST_BURST: begin
                if (burst_end) state_next = ST_CLK_POST;
            end
            ST_CLK_POST: begin
                if (timer_done) begin
`ifdef NANO_DSI_LINK_BTB_EN
                    if (arb_any) begin
                        arb_latch  = 1'b1;
                        state_next = ST_CLK_PRE;
                    end else begin
                        state_next = ST_CLK_STOP;
                    end
`else
                    state_next = ST_CLK_STOP;
`endif
                end
            end
            ST_CLK_STOP: begin
                if (!bus.clk_hs_rdy) state_next = ST_LP_GAP;
            end
            ST_LP_GAP: begin
                if (timer_done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // cfg bit7 is forced low so a bad setting cannot look like an already-expired timer.
    always_comb begin
        timer_load = '0;
        unique case (state_next)
            ST_CLK_PRE:  timer_load = {1'b0, cfg_clk_pre[TIMER_EXP_BIT-1:0]};
            ST_CLK_POST: timer_load = {1'b0, cfg_clk_post[TIMER_EXP_BIT-1:0]};
            ST_LP_GAP:   timer_load = {1'b0, cfg_lp_gap[TIMER_EXP_BIT-1:0]};
            default:     timer_load = '0;
        endcase
    end

    // NOTE: non-blocking assignments make every flop here sample pre-edge values together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            grant_q  <= '0;
            hs_req_q <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_next;
            timer_q  <= (state_next != state_q) ? timer_load : timer_q - timer_t'(1);
            // Outputs are registered from the next state so they change on the same edge as the FSM.
            grant_q  <= (state_next == ST_BURST) ? winner_oh : '0;
            hs_req_q <= state_next inside {ST_CLK_START, ST_CLK_PRE, ST_BURST, ST_CLK_POST};
            busy     <= (state_next != ST_IDLE);
        end
    end

    assign bus.grant      = grant_q;
    assign bus.clk_hs_req = hs_req_q;

endmodule
